// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store engine between the execute
// stage and the CPU memory request/response channels. Aligns and byte-masks
// stores onto the bus, extracts and extends loads, flags misaligned or
// illegal-size accesses without touching the bus, and counts stall cycles.
module mem_access_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic                op_write,
    input  logic [1:0]          op_size,
    input  logic                op_unsigned,
    input  logic [ADDR_W-1:0]   op_addr,
    input  logic [DATA_W-1:0]   op_wdata,
    input  logic [4:0]          op_rd,
    output logic [ADDR_W-1:0]   Address,
    output logic                MemWrite,
    output logic                MemRead,
    output logic [DATA_W-1:0]   Write_data,
    output logic [DATA_W/8-1:0] Write_strb,
    input  logic                Mem_Req_Ready,
    input  logic [DATA_W-1:0]   Read_data,
    input  logic                Read_data_Valid,
    output logic                Read_data_Ready,
    output logic                done_valid,
    output logic [DATA_W-1:0]   done_rdata,
    output logic [4:0]          done_rd,
    output logic                done_err,
    output logic [31:0]         stall_cnt
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam bit DBL_OK = (DATA_W == 64);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              write_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [4:0]        rd_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;
    logic [31:0]       stall_q;

    logic              acc_err;
    logic [OFF_W-1:0]  off_q;
    logic [OFF_W+2:0]  shamt;
    logic [BYTES-1:0]  strb_base;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] load_ext;
    logic              sign_bit;
    int unsigned       nbits;

    assign off_q = addr_q[OFF_W-1:0];
    assign shamt = {off_q, 3'b000};

    // Classify the incoming command: illegal size or natural misalignment
    always_comb begin
        acc_err = 1'b0;
        case (op_size)
            2'd0: acc_err = 1'b0;
            2'd1: acc_err = op_addr[0];
            2'd2: acc_err = |op_addr[1:0];
            default: acc_err = !DBL_OK || (|op_addr[2:0]);
        endcase
    end

    // Next-state selection for the access sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (op_valid) state_d = acc_err ? S_DONE : S_REQ;
            S_REQ:  if (Mem_Req_Ready) state_d = write_q ? S_DONE : S_RESP;
            S_RESP: if (Read_data_Valid) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Latch the command on accept and capture the extended load result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_q <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (state_q == S_IDLE && op_valid) begin
                write_q <= op_write;
                size_q  <= op_size;
                uns_q   <= op_unsigned;
                addr_q  <= op_addr;
                wdata_q <= op_wdata;
                rd_q    <= op_rd;
                err_q   <= acc_err;
                rdata_q <= '0;
            end
            if (state_q == S_RESP && Read_data_Valid) rdata_q <= load_ext;
        end
    end

    // Count cycles spent waiting on either memory channel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_q <= '0;
        else if ((state_q == S_REQ && !Mem_Req_Ready) ||
                 (state_q == S_RESP && !Read_data_Valid))
            stall_q <= stall_q + 32'd1;
    end

    // Byte-lane mask for the access size before lane shifting
    always_comb begin
        strb_base = '0;
        case (size_q)
            2'd0: strb_base = BYTES'(1);
            2'd1: strb_base = BYTES'(3);
            2'd2: strb_base = BYTES'(15);
            default: strb_base = '1;
        endcase
    end

    // Right-align the response, keep 2^size bytes and extend the rest
    always_comb begin
        load_ext = '0;
        shifted  = Read_data >> shamt;
        case (size_q)
            2'd0: begin sign_bit = shifted[7];  nbits = 8;  end
            2'd1: begin sign_bit = shifted[15]; nbits = 16; end
            2'd2: begin sign_bit = shifted[31]; nbits = 32; end
            default: begin sign_bit = shifted[DATA_W-1]; nbits = DATA_W; end
        endcase
        for (int unsigned i = 0; i < DATA_W; i++)
            load_ext[i] = (i < nbits) ? shifted[i] : (sign_bit & ~uns_q);
    end

    assign op_ready        = (state_q == S_IDLE);
    assign MemWrite        = (state_q == S_REQ) &&  write_q;
    assign MemRead         = (state_q == S_REQ) && !write_q;
    assign Address         = (state_q == S_REQ) ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign Write_strb      = (state_q == S_REQ) ? BYTES'(strb_base << off_q) : '0;
    assign Write_data      = (state_q == S_REQ) ? (wdata_q << shamt) : '0;
    assign Read_data_Ready = (state_q == S_RESP);
    assign done_valid      = (state_q == S_DONE);
    assign done_rdata      = (state_q == S_DONE) ? rdata_q : '0;
    assign done_rd         = (state_q == S_DONE) ? rd_q : '0;
    assign done_err        = (state_q == S_DONE) && err_q;
    assign stall_cnt       = stall_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a 32-bit and a 64-bit instance,
// directed scenarios followed by randomized accesses against an arithmetic model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int stall_m = 0;

    // 32-bit instance signals
    logic        op_valid, op_ready, op_write, op_unsigned;
    logic [1:0]  op_size;
    logic [31:0] op_addr, op_wdata;
    logic [4:0]  op_rd;
    logic [31:0] Address, Write_data, Read_data, done_rdata, stall_cnt;
    logic        MemWrite, MemRead, Mem_Req_Ready, Read_data_Valid, Read_data_Ready;
    logic [3:0]  Write_strb;
    logic        done_valid, done_err;
    logic [4:0]  done_rd;

    // 64-bit instance signals (ready/valid tied high)
    logic        op_valid_b, op_ready_b, op_write_b, op_unsigned_b;
    logic [1:0]  op_size_b;
    logic [31:0] op_addr_b, Address_b, stall_cnt_b;
    logic [63:0] op_wdata_b, Write_data_b, Read_data_b, done_rdata_b;
    logic [4:0]  op_rd_b, done_rd_b;
    logic        MemWrite_b, MemRead_b, Read_data_Ready_b, done_valid_b, done_err_b;
    logic [7:0]  Write_strb_b;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .op_write(op_write), .op_size(op_size), .op_unsigned(op_unsigned),
        .op_addr(op_addr), .op_wdata(op_wdata), .op_rd(op_rd),
        .Address(Address), .MemWrite(MemWrite), .MemRead(MemRead),
        .Write_data(Write_data), .Write_strb(Write_strb),
        .Mem_Req_Ready(Mem_Req_Ready), .Read_data(Read_data),
        .Read_data_Valid(Read_data_Valid), .Read_data_Ready(Read_data_Ready),
        .done_valid(done_valid), .done_rdata(done_rdata), .done_rd(done_rd),
        .done_err(done_err), .stall_cnt(stall_cnt)
    );

    mem_access_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (
        .clk(clk), .rst(rst), .op_valid(op_valid_b), .op_ready(op_ready_b),
        .op_write(op_write_b), .op_size(op_size_b), .op_unsigned(op_unsigned_b),
        .op_addr(op_addr_b), .op_wdata(op_wdata_b), .op_rd(op_rd_b),
        .Address(Address_b), .MemWrite(MemWrite_b), .MemRead(MemRead_b),
        .Write_data(Write_data_b), .Write_strb(Write_strb_b),
        .Mem_Req_Ready(1'b1), .Read_data(Read_data_b),
        .Read_data_Valid(1'b1), .Read_data_Ready(Read_data_Ready_b),
        .done_valid(done_valid_b), .done_rdata(done_rdata_b), .done_rd(done_rd_b),
        .done_err(done_err_b), .stall_cnt(stall_cnt_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: an access is an error if the size does not fit the bus or the
    // address is not a multiple of the access size in bytes.
    function automatic bit model_err(input int sz, input logic [31:0] addr, input int dw);
        if (sz == 3 && dw == 32) return 1'b1;
        return (addr % (32'd1 << sz)) != 0;
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] rdata, input int sz,
                                               input bit uns, input int off, input int dw);
        logic [63:0] v, mask;
        int nb;
        nb   = 1 << sz;
        mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
        v    = (rdata >> (8 * off)) & mask;
        if (!uns && v[8 * nb - 1]) v = v | ~mask;
        if (dw == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        return v;
    endfunction

    function automatic logic [63:0] model_strb(input int sz, input int off, input int bytes);
        logic [63:0] s;
        s = ((64'd1 << (1 << sz)) - 64'd1) << off;
        return s & ((64'd1 << bytes) - 64'd1);
    endfunction

    // One access on the 32-bit instance with configurable request/response waits
    task automatic acc32(input bit w, input int sz, input bit uns, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input logic [4:0] rd, input int rwait, input int vwait);
        bit err;
        int off;
        logic [31:0] exp_wd;
        err    = model_err(sz, addr, 32);
        off    = int'(addr % 4);
        exp_wd = wdata << (8 * off);
        op_valid = 1'b1; op_write = w; op_size = 2'(sz); op_unsigned = uns;
        op_addr = addr; op_wdata = wdata; op_rd = rd;
        check("idle_ready", op_ready, 1);
        check("idle_no_read", MemRead, 0);
        @(posedge clk); #1;
        op_valid = 1'b0;
        op_write = 1'($urandom); op_size = 2'($urandom); op_unsigned = 1'($urandom);
        op_addr = $urandom; op_wdata = $urandom; op_rd = 5'($urandom);
        if (err) begin
            check("err_done", done_valid, 1);
            check("err_flag", done_err, 1);
            check("err_rd", done_rd, rd);
            check("err_rdata", done_rdata, 0);
            check("err_memread", MemRead, 0);
            check("err_memwrite", MemWrite, 0);
            @(posedge clk); #1;
            check("err_done_clr", done_valid, 0);
            check("err_ready_back", op_ready, 1);
            return;
        end
        for (int k = 0; k <= rwait; k++) begin
            Mem_Req_Ready = (k == rwait);
            Read_data_Valid = 1'($urandom);
            op_valid = (k == rwait) ? 1'b0 : 1'($urandom);
            check("req_addr", Address, addr & 32'hFFFF_FFFC);
            check("req_write", MemWrite, w);
            check("req_read", MemRead, !w);
            check("req_strb", Write_strb, model_strb(sz, off, 4));
            if (w) check("req_wdata", Write_data, exp_wd);
            check("req_not_ready", op_ready, 0);
            check("req_no_rresp", Read_data_Ready, 0);
            @(posedge clk); #1;
            if (k != rwait) stall_m++;
        end
        Mem_Req_Ready = 1'b0; Read_data_Valid = 1'b0; op_valid = 1'b0;
        if (!w) begin
            for (int k = 0; k < vwait; k++) begin
                Read_data = $urandom;
                check("resp_ready", Read_data_Ready, 1);
                check("resp_no_read", MemRead, 0);
                check("resp_no_done", done_valid, 0);
                @(posedge clk); #1;
                stall_m++;
            end
            check("resp_ready_last", Read_data_Ready, 1);
            Read_data_Valid = 1'b1; Read_data = rdata;
            @(posedge clk); #1;
            Read_data_Valid = 1'b0; Read_data = $urandom;
        end
        check("done_valid", done_valid, 1);
        check("done_err", done_err, 0);
        check("done_rd", done_rd, rd);
        check("done_rdata", done_rdata, w ? 64'd0 : model_load({32'd0, rdata}, sz, uns, off, 32));
        check("done_not_ready", op_ready, 0);
        @(posedge clk); #1;
        check("done_clr", done_valid, 0);
        check("ready_back", op_ready, 1);
        check("stall_cnt", stall_cnt, stall_m);
    endtask

    // One access on the 64-bit instance, memory always ready
    task automatic acc64(input bit w, input int sz, input bit uns, input logic [31:0] addr,
                         input logic [63:0] wdata, input logic [63:0] rdata, input logic [4:0] rd);
        bit err;
        int off;
        err = model_err(sz, addr, 64);
        off = int'(addr % 8);
        op_valid_b = 1'b1; op_write_b = w; op_size_b = 2'(sz); op_unsigned_b = uns;
        op_addr_b = addr; op_wdata_b = wdata; op_rd_b = rd; Read_data_b = rdata;
        check("b_idle_ready", op_ready_b, 1);
        @(posedge clk); #1;
        op_valid_b = 1'b0;
        if (!err) begin
            check("b_req_addr", Address_b, addr & 32'hFFFF_FFF8);
            check("b_req_strb", Write_strb_b, model_strb(sz, off, 8));
            check("b_req_read", MemRead_b, !w);
            if (w) check("b_req_wdata", Write_data_b, wdata << (8 * off));
            @(posedge clk); #1;
            if (!w) begin
                check("b_resp_ready", Read_data_Ready_b, 1);
                @(posedge clk); #1;
            end
        end
        check("b_done_valid", done_valid_b, 1);
        check("b_done_err", done_err_b, err);
        check("b_done_rd", done_rd_b, rd);
        check("b_done_rdata", done_rdata_b, (w || err) ? 64'd0 : model_load(rdata, sz, uns, off, 64));
        @(posedge clk); #1;
        check("b_done_clr", done_valid_b, 0);
        check("b_stall", stall_cnt_b, 0);
    endtask

    initial begin
        int sz;
        logic [31:0] a;
        rst = 1'b1;
        op_valid = 0; op_write = 0; op_size = 0; op_unsigned = 0; op_addr = 0; op_wdata = 0; op_rd = 0;
        Mem_Req_Ready = 0; Read_data = 0; Read_data_Valid = 0;
        op_valid_b = 0; op_write_b = 0; op_size_b = 0; op_unsigned_b = 0; op_addr_b = 0;
        op_wdata_b = 0; op_rd_b = 0; Read_data_b = 0;
        @(posedge clk); #1;
        check("rst_ready", op_ready, 1);
        check("rst_done", done_valid, 0);
        check("rst_read", MemRead, 0);
        check("rst_write", MemWrite, 0);
        check("rst_addr", Address, 0);
        check("rst_strb", Write_strb, 0);
        check("rst_rresp", Read_data_Ready, 0);
        check("rst_stall", stall_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed scenarios
        acc32(1, 0, 0, 32'h1003, 32'h0000_00A5, 32'h0, 5'd3, 0, 0);
        acc32(0, 1, 0, 32'h2002, 32'h0, 32'h8001_1234, 5'd7, 0, 3);
        acc32(0, 0, 1, 32'h2001, 32'h0, 32'h0000_F000, 5'd9, 0, 0);
        acc32(0, 0, 0, 32'h2001, 32'h0, 32'h0000_F000, 5'd10, 0, 0);
        acc32(0, 2, 0, 32'h1002, 32'h0, 32'h0, 5'd11, 0, 0);
        acc32(0, 3, 0, 32'h1000, 32'h0, 32'h0, 5'd12, 0, 0);
        acc32(1, 2, 0, 32'h4000, 32'hDEAD_BEEF, 32'h0, 5'd13, 4, 0);
        acc32(0, 2, 1, 32'h4004, 32'h0, 32'hCAFE_F00D, 5'd14, 1, 1);

        // Reset while waiting for the read response
        op_valid = 1; op_write = 0; op_size = 2; op_unsigned = 0; op_addr = 32'h3000; op_rd = 5'd15;
        @(posedge clk); #1;
        op_valid = 0; Mem_Req_Ready = 1;
        @(posedge clk); #1;
        Mem_Req_Ready = 0;
        check("abort_in_resp", Read_data_Ready, 1);
        #3 rst = 1'b1;
        #1;
        check("abort_rresp_drop", Read_data_Ready, 0);
        check("abort_no_done", done_valid, 0);
        check("abort_ready", op_ready, 1);
        check("abort_stall", stall_cnt, 0);
        stall_m = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        Read_data_Valid = 1; Read_data = 32'h1234_5678;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("post_abort_no_done", done_valid, 0);
            check("post_abort_ready", op_ready, 1);
        end
        Read_data_Valid = 0;

        // 64-bit bus
        acc64(0, 3, 0, 32'h8, 64'h0, 64'h0123_4567_89AB_CDEF, 5'd20);
        acc64(0, 3, 0, 32'hC, 64'h0, 64'h0123_4567_89AB_CDEF, 5'd21);
        acc64(1, 3, 0, 32'h10, 64'hFEDC_BA98_7654_3210, 64'h0, 5'd22);
        acc64(0, 2, 0, 32'h14, 64'h0, 64'h8765_4321_0000_0000, 5'd23);

        // Randomized accesses
        for (int n = 0; n < 30; n++) begin
            sz = int'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 4) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            acc32(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom, 5'($urandom),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        for (int n = 0; n < 12; n++) begin
            sz = int'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 4) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            acc64(1'($urandom), sz, 1'($urandom), a, {$urandom, $urandom}, {$urandom, $urandom},
                  5'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store engine between the custom CPU execute stage and the CPU memory request/response channels.
- Accepts one access command at a time, aligns and byte-masks it onto a DATA_W-wide bus, and drives the valid/ready handshakes.
- For loads, extracts and sign- or zero-extends the result; for stores, completes after the request handshake.
- Flags misaligned accesses without touching the bus, and counts memory stall cycles for the performance counters.

Parameters:
- DATA_W, 32: bus data width; legal values 32 or 64. Defines BYTES = DATA_W/8 and OFF_W = log2(BYTES).
- ADDR_W, 32: address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- op_valid  in  1  access command valid
- op_ready  out  1  unit can accept a command
- op_write  in  1  1 = store, 0 = load
- op_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double
- op_unsigned  in  1  zero-extend load result
- op_addr  in  ADDR_W  byte address
- op_wdata  in  DATA_W  store data, right-aligned
- op_rd  in  5  destination register tag
- Address  out  ADDR_W  bus address, low OFF_W bits forced to 0
- MemWrite  out  1  write request
- MemRead  out  1  read request
- Write_data  out  DATA_W  lane-shifted store data
- Write_strb  out  BYTES  byte-lane strobes
- Mem_Req_Ready  in  1  request accepted
- Read_data  in  DATA_W  read response data
- Read_data_Valid  in  1  read response valid
- Read_data_Ready  out  1  ready for read response
- done_valid  out  1  one-cycle completion pulse
- done_rdata  out  DATA_W  extended load result
- done_rd  out  5  tag of the completing access
- done_err  out  1  misaligned or illegal size
- stall_cnt  out  32  memory stall cycle counter

Behaviour:
- Reset: state IDLE. All outputs are 0 except op_ready = 1, including stall_cnt = 0.
- Reset mid-operation aborts the access at once: outputs drop asynchronously and no done pulse is produced.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - op_ready = 1.
  - When op_valid is high, latch all op_* fields.
  - Error check: op_size = 3 with DATA_W = 32 is an error; op_addr not a multiple of 2^op_size is an error. On error, go to DONE with err = 1.
  - Otherwise go to REQ.
- REQ:
  - MemWrite = op_write and MemRead = !op_write.
  - Outputs are computed with off = op_addr[OFF_W-1:0].
  - Address = op_addr with the low OFF_W bits cleared.
  - Write_strb = ((1 << 2^size) - 1) << off.
  - Write_data = op_wdata << (8*off).
  - All request outputs stay stable until Mem_Req_Ready is seen.
  - On Mem_Req_Ready: a store goes to DONE; a load goes to RESP.
  - Read_data_Valid is ignored in this state.
- RESP:
  - Read_data_Ready = 1.
  - On Read_data_Valid: capture Read_data >> (8*off), truncate to 2^size bytes, extend (sign unless op_unsigned), then go to DONE.
- DONE:
  - done_valid = 1 for exactly one cycle, with done_rd and done_err valid.
  - done_rdata is 0 for stores and errors.
  - op_ready = 0; the next state is IDLE.
- Latency:
  - Store with immediate ready: accept at cycle N, request at N+1, done at N+2.
  - Load with ready and valid in the same-or-next cycle: done at N+3 minimum.
  - Error: done at N+1.
- Only one access is outstanding at a time. op_valid is ignored outside IDLE.
- stall_cnt increments every cycle spent in REQ with Mem_Req_Ready = 0, or in RESP with Read_data_Valid = 0. It wraps from 0xFFFFFFFF to 0.
- A double access (DATA_W = 64, size 3) uses strobes 8'hFF and is legal only when 8-aligned.

Test Plan:
1. DATA_W=32, store byte addr 0x1003, wdata 0x000000A5, Mem_Req_Ready tied 1 -> Address 0x1000, Write_data 0xA5000000, Write_strb 4'b1000; done_valid 2 cycles after accept; stall_cnt stays 0.
2. Signed load half addr 0x2002; Read_data 0x80011234 returned after 3 RESP wait cycles -> done_rdata 0xFFFF8001; stall_cnt = 3.
3. Unsigned load byte addr 0x2001, Read_data 0x0000F000 -> done_rdata 0x000000F0; same access with op_unsigned=0 -> 0xFFFFFFF0.
4. Load word addr 0x1002 -> MemRead/MemWrite never asserted; done_valid with done_err=1 at N+1. DATA_W=32 with op_size=3 -> the same error result.
5. Store word with Mem_Req_Ready low for 4 cycles -> Address, Write_data and Write_strb stable throughout; stall_cnt = 4; op_valid pulses during the stall are ignored.
6. rst asserted while in RESP -> Read_data_Ready falls in the same cycle; no done_valid; op_ready = 1 after release. DATA_W=64 load double addr 0x8, Read_data 0x0123456789ABCDEF -> done_rdata unchanged.
